// File: rtl/uart_cmd_link.sv
// Full-duplex UART command/response link: framed command packets in, multi-byte messages out.
// RX and TX share nothing but the clock; loopback of uart_tx onto uart_rx is legal.
module uart_cmd_link #(
   parameter int CLK_MHZ       = 84,
   parameter int BAUD          = 921600,
   parameter int TX_BYTES      = 2,
   parameter int TIMEOUT_BYTES = 4
) (
   input  logic                  clk_PSRAM,
   input  logic                  rst,
   input  logic                  uart_rx,
   output logic                  uart_tx,
   input  logic                  tx_valid,
   input  logic [8*TX_BYTES-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  tx_done,
   output logic [7:0]            trigger,
   output logic [12:0]           threshold,
   output logic [23:0]           samples_after,
   output logic [23:0]           samples_before,
   output logic                  flag_acq,
   output logic                  flag_debug,
   output logic                  rx_err,
   output logic [1:0]            rx_err_code
);
   localparam int DIV      = CLK_MHZ * 1_000_000 / BAUD;
   localparam int TO_LIMIT = TIMEOUT_BYTES * 10 * DIV;
   localparam int CW       = $clog2(DIV);
   localparam int TW       = $clog2(TO_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // ---------------- RX bit engine ----------------
   state_t          rx_st, rx_nx;
   logic            rx_m, rx_sync;
   logic [CW-1:0]   rx_cnt;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_sh;
   logic            rx_tick, byte_ok, frm_err;

   always_comb begin
      rx_nx   = rx_st;
      rx_tick = 1'b0;
      case (rx_st)
         S_IDLE:  if (!rx_sync) rx_nx = S_START;
         S_START: if (rx_cnt == CW'(DIV/2 - 1)) rx_nx = rx_sync ? S_IDLE : S_DATA;
         S_DATA:  if (rx_cnt == CW'(DIV - 1)) begin
                     rx_tick = 1'b1;
                     if (rx_bit == 3'd7) rx_nx = S_STOP;
                  end
         S_STOP:  if (rx_cnt == CW'(DIV - 1)) rx_nx = S_IDLE;
         default: rx_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_sync <= 1'b1;
         rx_st   <= S_IDLE;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
         byte_ok <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         rx_m    <= uart_rx;
         rx_sync <= rx_m;
         rx_st   <= rx_nx;
         byte_ok <= 1'b0;
         frm_err <= 1'b0;
         if (rx_nx != rx_st || rx_tick) rx_cnt <= '0;
         else                           rx_cnt <= rx_cnt + 1'b1;
         if (rx_tick) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
         end
         if (rx_st == S_STOP && rx_nx == S_IDLE) begin
            byte_ok <= rx_sync;
            frm_err <= !rx_sync;
         end
      end
   end

   // ---------------- packet assembler + inter-byte timeout ----------------
   logic [3:0]    idx;
   logic [TW-1:0] to_cnt;
   logic [7:0]    s_trig;
   logic [12:0]   s_thr;
   logic [23:0]   s_sa;
   logic [15:0]   s_sb;

   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         idx            <= '0;
         to_cnt         <= '0;
         s_trig         <= '0;
         s_thr          <= '0;
         s_sa           <= '0;
         s_sb           <= '0;
         trigger        <= '0;
         threshold      <= '0;
         samples_after  <= '0;
         samples_before <= '0;
         flag_acq       <= 1'b0;
         flag_debug     <= 1'b0;
         rx_err         <= 1'b0;
         rx_err_code    <= '0;
      end else begin
         flag_acq   <= 1'b0;
         flag_debug <= 1'b0;
         rx_err     <= 1'b0;
         // a start edge in the limit cycle lands in the else branch and wins
         if (idx != 4'd0 && rx_st == S_IDLE && rx_sync) begin
            if (to_cnt == TW'(TO_LIMIT - 1)) begin
               to_cnt      <= '0;
               idx         <= '0;
               rx_err      <= 1'b1;
               rx_err_code <= 2'd1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end

         if (frm_err) begin
            idx         <= '0;
            rx_err      <= 1'b1;
            rx_err_code <= 2'd0;
         end else if (byte_ok) begin
            case (idx)
               4'd0: begin
                  if (rx_sh == 8'h41) idx <= 4'd1;
                  else if (rx_sh == 8'h53) flag_debug <= 1'b1;
                  else begin
                     rx_err      <= 1'b1;
                     rx_err_code <= 2'd2;
                  end
               end
               4'd1: s_trig        <= rx_sh;
               4'd2: s_thr[12:8]   <= rx_sh[4:0];
               4'd3: s_thr[7:0]    <= rx_sh;
               4'd4: s_sa[23:16]   <= rx_sh;
               4'd5: s_sa[15:8]    <= rx_sh;
               4'd6: s_sa[7:0]     <= rx_sh;
               4'd7: s_sb[15:8]    <= rx_sh;
               4'd8: s_sb[7:0]     <= rx_sh;
               default: begin
                  trigger        <= s_trig;
                  threshold      <= s_thr;
                  samples_after  <= s_sa;
                  samples_before <= {s_sb, rx_sh};
                  flag_acq       <= 1'b1;
               end
            endcase
            if (idx >= 4'd1 && idx <= 4'd8) idx <= idx + 1'b1;
            else if (idx == 4'd9)           idx <= '0;
         end
      end
   end

   // ---------------- TX ----------------
   state_t                tx_st, tx_nx;
   logic [CW-1:0]         tx_cnt;
   logic [2:0]            tx_bit;
   logic [2:0]            tx_byte;
   logic [8*TX_BYTES-1:0] tx_buf;
   logic [7:0]            tx_cur;
   logic                  tx_tick;

   assign tx_cur  = tx_buf[8*TX_BYTES-1 -: 8];
   assign tx_tick = (tx_cnt == CW'(DIV - 1));

   always_comb begin
      tx_nx    = tx_st;
      uart_tx  = 1'b1;
      tx_ready = 1'b0;
      case (tx_st)
         S_IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) tx_nx = S_START;
         end
         S_START: begin
            uart_tx = 1'b0;
            if (tx_tick) tx_nx = S_DATA;
         end
         S_DATA: begin
            uart_tx = tx_cur[tx_bit];
            if (tx_tick && tx_bit == 3'd7) tx_nx = S_STOP;
         end
         S_STOP: if (tx_tick) tx_nx = (tx_byte == 3'(TX_BYTES - 1)) ? S_IDLE : S_START;
         default: tx_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_PSRAM) begin
      if (rst) begin
         tx_st   <= S_IDLE;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_byte <= '0;
         tx_buf  <= '0;
         tx_done <= 1'b0;
      end else begin
         tx_st   <= tx_nx;
         tx_done <= 1'b0;
         if (tx_st == S_IDLE) begin
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
            if (tx_valid) tx_buf <= tx_data;
         end else if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_st == S_DATA) tx_bit <= tx_bit + 1'b1;
            if (tx_st == S_STOP) begin
               if (tx_nx == S_IDLE) tx_done <= 1'b1;
               else begin
                  tx_byte <= tx_byte + 1'b1;
                  tx_buf  <= tx_buf << 8;
               end
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Scoreboard bench for uart_cmd_link: stimulus pushes expected events, monitors pop and compare.
module tb_uart_cmd_link;
   localparam int DIV = 8;
   localparam int K_ACQ = 0, K_DBG = 1, K_ERR = 2, K_TXB = 3, K_DONE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        uart_rx, uart_tx;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = 16'h0;
   logic        tx_ready, tx_done;
   logic [7:0]  trigger;
   logic [12:0] threshold;
   logic [23:0] samples_after, samples_before;
   logic        flag_acq, flag_debug, rx_err;
   logic [1:0]  rx_err_code;

   always #5 clk = ~clk;
   assign uart_rx = loop ? uart_tx : rx_drv;

   uart_cmd_link #(.CLK_MHZ(8), .BAUD(1_000_000), .TX_BYTES(2), .TIMEOUT_BYTES(4)) dut (
      .clk_PSRAM(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_done(tx_done),
      .trigger(trigger), .threshold(threshold), .samples_after(samples_after),
      .samples_before(samples_before), .flag_acq(flag_acq), .flag_debug(flag_debug),
      .rx_err(rx_err), .rx_err_code(rx_err_code));

   typedef struct { int kind; logic [71:0] val; } ev_t;
   ev_t  rx_q[$], tx_q[$];
   int   acc_q[$];
   int   n_chk = 0, n_pass = 0, cyc = 0;
   logic mon_on = 1'b0;

   logic [7:0]  pkt1 [10] = '{8'h41, 8'h54, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20};
   logic [7:0]  pkt2 [10] = '{8'h41, 8'h42, 8'hFF, 8'hFF, 8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
   logic [15:0] words [5] = '{16'h4154, 16'h0010, 16'h0001, 16'h0000, 16'h0020};

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [71:0] acq_v(input logic [7:0] t, input logic [12:0] th,
                                         input logic [23:0] sa, input logic [23:0] sb);
      return {3'b0, t, th, sa, sb};
   endfunction

   task automatic push_rx(input int k, input logic [71:0] v);
      ev_t e; e.kind = k; e.val = v; rx_q.push_back(e);
   endtask

   task automatic push_tx(input int k, input logic [71:0] v);
      ev_t e; e.kind = k; e.val = v; tx_q.push_back(e);
   endtask

   task automatic pop_cmp(input string name, input int is_tx, input int k, input logic [71:0] v);
      ev_t e;
      if ((is_tx != 0 ? tx_q.size() : rx_q.size()) == 0) begin
         n_chk++;
         $display("FAIL %s: unexpected event kind %0d val %0h, nothing pending", name, k, v);
      end else begin
         e = (is_tx != 0) ? tx_q.pop_front() : rx_q.pop_front();
         check({name, " kind"}, 72'(k), 72'(e.kind));
         check(name, v, e.val);
      end
   endtask

   // cycle counter and TX acceptance log (message length measurement)
   initial forever begin
      @(posedge clk);
      if (!rst && tx_valid && tx_ready) acc_q.push_back(cyc + 1);
      cyc++;
   end

   // RX-side monitor
   initial forever begin
      @(negedge clk);
      if (mon_on) begin
         if (flag_acq)   pop_cmp("acq", 0, K_ACQ, {3'b0, trigger, threshold, samples_after, samples_before});
         if (flag_debug) pop_cmp("debug", 0, K_DBG, 72'h0);
         if (rx_err)     pop_cmp("rx_err", 0, K_ERR, 72'(rx_err_code));
      end
   end

   // tx_done monitor
   initial forever begin
      @(negedge clk);
      if (mon_on && tx_done) begin
         check("tx_ready at done", 72'(tx_ready), 72'h1);
         pop_cmp("tx_done", 1, K_DONE, 72'h0);
         if (acc_q.size() != 0) check("tx_len", 72'(cyc - acc_q.pop_front()), 72'd160);
      end
   end

   // uart_tx line decoder, sampling mid-bit; a frame cut by reset is dropped
   initial forever begin
      logic [7:0] b;
      logic       st, sp, abort;
      @(negedge clk);
      if (mon_on && uart_tx === 1'b0) begin
         abort = 1'b0;
         for (int i = 0; i < 4; i++) begin @(negedge clk); if (rst) abort = 1'b1; end
         st = uart_tx;
         for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < DIV; i++) begin @(negedge clk); if (rst) abort = 1'b1; end
            b[k] = uart_tx;
         end
         for (int i = 0; i < DIV; i++) begin @(negedge clk); if (rst) abort = 1'b1; end
         sp = uart_tx;
         if (!abort) pop_cmp("tx_frame", 1, K_TXB, 72'({st, sp, b}));
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx_drv = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx_drv = stop;
      repeat (DIV) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain(input string name, input int bound);
      for (int i = 0; i < bound && (rx_q.size() != 0 || tx_q.size() != 0); i++) @(negedge clk);
      n_chk++;
      if (rx_q.size() == 0 && tx_q.size() == 0) n_pass++;
      else $display("FAIL %s: %0d rx / %0d tx events pending after %0d cycles, required 0",
                    name, rx_q.size(), tx_q.size(), bound);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset ctrl", 72'({uart_tx, tx_ready, tx_done, flag_acq, flag_debug, rx_err, rx_err_code}),
            72'h0C0);
      check("reset fields", {3'b0, trigger, threshold, samples_after, samples_before}, 72'h0);
      rst = 1'b0;
      mon_on = 1'b1;
      repeat (4) @(negedge clk);

      // 1: acquisition packet
      push_rx(K_ACQ, acq_v(8'h54, 13'h0010, 24'h000100, 24'h000020));
      foreach (pkt1[i]) send_byte(pkt1[i], 1'b1);
      drain("case1 acq", 200);

      // 2: two-byte TX message, data changes while busy are ignored
      push_tx(K_TXB, 72'({1'b0, 1'b1, 8'hA5}));
      push_tx(K_TXB, 72'({1'b0, 1'b1, 8'h5A}));
      push_tx(K_DONE, 72'h0);
      tx_data = 16'hA55A; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0; tx_data = 16'hFFFF;
      check("tx_ready busy", 72'(tx_ready), 72'h0);
      drain("case2 tx", 300);

      // 3: glitch rejected, then debug command
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (40) @(negedge clk);
      push_rx(K_DBG, 72'h0);
      send_byte(8'h53, 1'b1);
      drain("case3 debug", 50);

      // 4: stale packet times out, next packet decodes
      push_rx(K_ERR, 72'd1);
      send_byte(8'h41, 1'b1); send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
      drain("case4 timeout", 450);
      push_rx(K_ACQ, acq_v(8'h42, 13'h1FFF, 24'hABCDEF, 24'h123456));
      foreach (pkt2[i]) send_byte(pkt2[i], 1'b1);
      drain("case4 acq", 200);

      // 5: framing error then unknown opcode; fields untouched
      push_rx(K_ERR, 72'd0);
      send_byte(8'h41, 1'b0);
      repeat (20) @(negedge clk);
      push_rx(K_ERR, 72'd2);
      send_byte(8'h7E, 1'b1);
      drain("case5 errs", 100);
      repeat (10) @(negedge clk);
      check("rx_err_code held", 72'(rx_err_code), 72'd2);
      check("fields held", {3'b0, trigger, threshold, samples_after, samples_before},
            acq_v(8'h42, 13'h1FFF, 24'hABCDEF, 24'h123456));

      // 6: reset during second TX byte, then loopback of the case-1 packet
      push_tx(K_TXB, 72'({1'b0, 1'b1, 8'hA5}));
      tx_data = 16'hA55A; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (120) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset mid tx", 72'({uart_tx, tx_ready, tx_done}), 72'b110);
      @(negedge clk);
      rst = 1'b0;
      acc_q.delete();
      repeat (200) @(negedge clk);
      drain("case6 abort", 10);

      loop = 1'b1;
      push_rx(K_ACQ, acq_v(8'h54, 13'h0010, 24'h000100, 24'h000020));
      foreach (words[w]) begin
         push_tx(K_TXB, 72'({1'b0, 1'b1, words[w][15:8]}));
         push_tx(K_TXB, 72'({1'b0, 1'b1, words[w][7:0]}));
         push_tx(K_DONE, 72'h0);
      end
      foreach (words[w]) begin
         tx_data = words[w]; tx_valid = 1'b1;
         for (int k = 0; k < 400 && !tx_ready; k++) @(negedge clk);
         check("loopback accept", 72'(tx_ready), 72'h1);
         @(negedge clk);
      end
      tx_valid = 1'b0;
      drain("case6 loopback", 1200);
      loop = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
